// File: rtl/manchester_frame_decoder_pkg.sv
// Shared types and constants for the Manchester frame decoder slice.
package manchester_frame_decoder_pkg;

  localparam int FRAME_BITS_DEF = 44;
  localparam int CNT_W_DEF      = 6;

  // Wiegand-26 layout inside frame_data[25:0]
  localparam int W26_FAC_LSB  = 17;  // facility code, 8 bits
  localparam int W26_CARD_LSB = 1;   // card number, 16 bits
  localparam int W26_SPLIT    = 13;  // bit25 covers [24:13] even, bit0 covers [12:1] odd

  localparam logic [1:0] ERR_PAIR  = 2'b01;
  localparam logic [1:0] ERR_SHORT = 2'b10;

  typedef enum logic {
    HALF0 = 1'b0,   // awaiting first half of a pair
    HALF1 = 1'b1    // awaiting second half of a pair
  } state_t;

  // Datapath action chosen by the FSM for the current cycle
  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_HALF0,      // capture first half-bit
    ACT_SHIFT,      // valid pair, frame not yet complete
    ACT_FRAME,      // valid pair completing the frame
    ACT_SLIP,       // invalid first pair absorbed as a one-half-bit realignment
    ACT_PAIR_ERR,   // invalid pair, abort frame
    ACT_DONE        // upstream stream end
  } act_t;

endpackage

// File: rtl/manchester_frame_decoder_if.sv
// Half-bit stream in, decoded frame and status out.
interface manchester_frame_decoder_if
  import manchester_frame_decoder_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEF
);
  logic                  bit_in;
  logic                  bit_toggle;
  logic                  stream_done;
  logic [FRAME_BITS-1:0] frame_data;
  logic                  frame_valid;
  logic [7:0]            facility;
  logic [15:0]           card_num;
  logic                  parity_ok;
  logic                  frame_err;
  logic [1:0]            err_code;
  logic [7:0]            frame_cnt;

  // Upstream slicer / consumer side
  modport master (
    output bit_in, bit_toggle, stream_done,
    input  frame_data, frame_valid, facility, card_num, parity_ok,
           frame_err, err_code, frame_cnt
  );

  // Decoder side
  modport slave (
    input  bit_in, bit_toggle, stream_done,
    output frame_data, frame_valid, facility, card_num, parity_ok,
           frame_err, err_code, frame_cnt
  );
endinterface

// File: rtl/manchester_frame_decoder_wiegand26_check.sv
// Combinational Wiegand-26 field extraction and parity check.
module wiegand26_check
  import manchester_frame_decoder_pkg::*;
(
  input  logic [25:0] i_w26,
  output logic [7:0]  o_facility,
  output logic [15:0] o_card_num,
  output logic        o_parity_ok
);

  assign o_facility  = i_w26[W26_FAC_LSB  +: 8];
  assign o_card_num  = i_w26[W26_CARD_LSB +: 16];
  // Leading bit makes the upper half even, trailing bit makes the lower half odd
  assign o_parity_ok = ~(^i_w26[25:W26_SPLIT]) & (^i_w26[W26_SPLIT-1:0]);

endmodule

// File: rtl/manchester_frame_decoder.sv
// Pairs half-bits into Manchester data bits, assembles MSB-first frames,
// and reports Wiegand-26 fields plus framing errors.
module manchester_frame_decoder
  import manchester_frame_decoder_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter int CNT_W      = CNT_W_DEF
)(
  input  logic                         sqwv,
  input  logic                         rst_n,
  manchester_frame_decoder_if.slave    dec
);

  state_t                r_state, w_state_nxt;
  act_t                  w_act;
  logic                  r_prev_toggle, r_prev_done;
  logic                  r_h0, r_slip_used;
  logic [FRAME_BITS-2:0] r_shreg;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [FRAME_BITS-1:0] r_frame_data;
  logic                  r_frame_valid, r_frame_err;
  logic [1:0]            r_err_code;
  logic [7:0]            r_frame_cnt;

  logic w_evt, w_done_rise, w_pair_ok, w_last;

  assign w_evt       = dec.bit_toggle ^ r_prev_toggle;
  assign w_done_rise = dec.stream_done & ~r_prev_done;
  assign w_pair_ok   = r_h0 ^ dec.bit_in;                 // 10 or 01
  assign w_last      = (r_bit_cnt == CNT_W'(FRAME_BITS - 1));

  // State register
  always_ff @(posedge sqwv or negedge rst_n) begin
    if (!rst_n) r_state <= HALF0;
    else        r_state <= w_state_nxt;
  end

  // Next state and datapath action; stream end overrides a same-cycle half-bit
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    w_state_nxt = r_state;
    w_act       = ACT_NONE;
    if (w_done_rise) begin
      w_act       = ACT_DONE;
      w_state_nxt = HALF0;
    end else if (w_evt) begin
      if (r_state == HALF0) begin
        w_act       = ACT_HALF0;
        w_state_nxt = HALF1;
      end else if (w_pair_ok) begin
        w_act       = w_last ? ACT_FRAME : ACT_SHIFT;
        w_state_nxt = HALF0;
      end else if (r_bit_cnt == '0 && !r_slip_used) begin
        w_act       = ACT_SLIP;
        w_state_nxt = HALF1;
      end else begin
        w_act       = ACT_PAIR_ERR;
        w_state_nxt = HALF0;
      end
    end
  end

  // Edge detectors, shift register, counters and registered status outputs
  always_ff @(posedge sqwv or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_toggle <= 1'b0;
      r_prev_done   <= 1'b0;
      r_h0          <= 1'b0;
      r_slip_used   <= 1'b0;
      r_shreg       <= '0;
      r_bit_cnt     <= '0;
      r_frame_data  <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_err_code    <= 2'b00;
      r_frame_cnt   <= 8'd0;
    end else begin
      // NOTE: non-blocking so every register here sees pre-edge values of the others.
      r_prev_toggle <= dec.bit_toggle;
      r_prev_done   <= dec.stream_done;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      case (w_act)
        ACT_HALF0: r_h0 <= dec.bit_in;
        ACT_SLIP: begin
          r_h0        <= dec.bit_in;
          r_slip_used <= 1'b1;
        end
        ACT_SHIFT: begin
          r_shreg   <= {r_shreg[FRAME_BITS-3:0], r_h0};
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
        ACT_FRAME: begin
          r_frame_data  <= {r_shreg, r_h0};
          r_frame_valid <= 1'b1;
          r_frame_cnt   <= r_frame_cnt + 8'd1;
          r_shreg       <= '0;
          r_bit_cnt     <= '0;
          r_slip_used   <= 1'b0;
        end
        ACT_PAIR_ERR: begin
          r_frame_err <= 1'b1;
          r_err_code  <= ERR_PAIR;
          r_shreg     <= '0;
          r_bit_cnt   <= '0;
          r_slip_used <= 1'b0;
        end
        ACT_DONE: begin
          if (r_bit_cnt != '0 || r_state == HALF1) begin
            r_frame_err <= 1'b1;
            r_err_code  <= ERR_SHORT;
          end
          r_shreg     <= '0;
          r_bit_cnt   <= '0;
          r_slip_used <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  wiegand26_check u_w26 (
    .i_w26       (r_frame_data[25:0]),
    .o_facility  (dec.facility),
    .o_card_num  (dec.card_num),
    .o_parity_ok (dec.parity_ok)
  );

  assign dec.frame_data  = r_frame_data;
  assign dec.frame_valid = r_frame_valid;
  assign dec.frame_err   = r_frame_err;
  assign dec.err_code    = r_err_code;
  assign dec.frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_manchester_frame_decoder.sv
// Self-checking bench for manchester_frame_decoder.
module tb_manchester_frame_decoder;
  import manchester_frame_decoder_pkg::*;

  localparam int FB = 44;

  logic sqwv  = 1'b0;
  logic rst_n = 1'b0;
  always #5 sqwv = ~sqwv;

  manchester_frame_decoder_if #(.FRAME_BITS(FB)) dec_if ();

  manchester_frame_decoder #(.FRAME_BITS(FB), .CNT_W(6)) dut (
    .sqwv  (sqwv),
    .rst_n (rst_n),
    .dec   (dec_if)
  );

  typedef struct {
    logic [FB-1:0] data;
    logic [7:0]    fac;
    logic [15:0]   card;
    logic          par;
    logic [7:0]    cnt;
  } obs_t;

  typedef struct {
    logic [FB-1:0] frame;
    bit            lead;   // extra leading '1' half-bit (frame MSB must be 1)
    logic [7:0]    fac;
    logic [15:0]   card;
    logic          par;
  } vec_t;

  obs_t       obs_q[$];
  logic [1:0] err_q[$];
  int         n_pass  = 0;
  int         n_total = 0;
  logic [7:0] exp_cnt = 8'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: Wiegand parity from bit counts
  function automatic logic model_parity(input logic [FB-1:0] f);
    logic [25:0] w;
    w = f[25:0];
    return (($countones(w[25:13]) % 2) == 0) && (($countones(w[12:0]) % 2) == 1);
  endfunction

  // Observe outputs mid-cycle
  always @(negedge sqwv) begin
    if (rst_n) begin
      if (dec_if.frame_valid || dec_if.frame_err)
        check("valid_err_exclusive", 64'(dec_if.frame_valid & dec_if.frame_err), 64'd0);
      if (dec_if.frame_valid)
        obs_q.push_back('{dec_if.frame_data, dec_if.facility, dec_if.card_num,
                          dec_if.parity_ok, dec_if.frame_cnt});
      if (dec_if.frame_err) err_q.push_back(dec_if.err_code);
    end
  end

  task automatic send_half(input logic b, input int gap);
    @(negedge sqwv);
    dec_if.bit_in     = b;
    dec_if.bit_toggle = ~dec_if.bit_toggle;
    repeat (gap) @(negedge sqwv);
  endtask

  // Sends the top nbits of v, MSB first, as Manchester pairs (1 -> 10, 0 -> 01)
  task automatic send_bits(input logic [FB-1:0] v, input int nbits, input int max_gap);
    for (int i = FB - 1; i >= FB - nbits; i--) begin
      send_half(v[i], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
      send_half(~v[i], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
    end
  endtask

  task automatic settle();
    repeat (3) @(negedge sqwv);
  endtask

  task automatic expect_frame(input string tag, input logic [FB-1:0] f, input logic [7:0] fac,
                              input logic [15:0] card, input logic par, input logic [7:0] cnt);
    obs_t o;
    check({tag, "_nvalid"}, obs_q.size(), 1);
    check({tag, "_nerr"}, err_q.size(), 0);
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      check({tag, "_data"}, o.data, f);
      check({tag, "_fac"},  o.fac,  fac);
      check({tag, "_card"}, o.card, card);
      check({tag, "_par"},  o.par,  par);
      check({tag, "_cnt"},  o.cnt,  cnt);
    end
    obs_q.delete();
    err_q.delete();
  endtask

  task automatic expect_err(input string tag, input logic [1:0] code);
    check({tag, "_nerr"}, err_q.size(), 1);
    check({tag, "_nvalid"}, obs_q.size(), 0);
    if (err_q.size() > 0) check({tag, "_code"}, err_q.pop_front(), code);
    obs_q.delete();
    err_q.delete();
  endtask

  task automatic random_frame(input string tag, input int max_gap);
    logic [FB-1:0] f;
    f = {12'($urandom), $urandom};
    send_bits(f, FB, max_gap);
    settle();
    exp_cnt++;
    expect_frame(tag, f, f[24:17], f[16:1], model_parity(f), exp_cnt);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},  dec_if.frame_data,  0);
    check({tag, "_valid"}, dec_if.frame_valid, 0);
    check({tag, "_err"},   dec_if.frame_err,   0);
    check({tag, "_code"},  dec_if.err_code,    0);
    check({tag, "_cnt"},   dec_if.frame_cnt,   0);
    check({tag, "_fac"},   dec_if.facility,    0);
    check({tag, "_card"},  dec_if.card_num,    0);
    check({tag, "_par"},   dec_if.parity_ok,   0);
  endtask

  vec_t          vecs[6];
  logic [FB-1:0] f;

  initial begin
    vecs[0] = '{44'h000_0202_0002, 1'b0, 8'h01, 16'h0001, 1'b1};  // facility 1, card 1
    vecs[1] = '{44'h000_0002_0002, 1'b0, 8'h01, 16'h0001, 1'b0};  // bit25 flipped
    vecs[2] = '{44'h000_0200_4003, 1'b0, 8'h00, 16'h2001, 1'b0};
    vecs[3] = '{44'h800_0000_0001, 1'b1, 8'h00, 16'h0000, 1'b1};  // slip absorbed
    vecs[4] = '{44'hFFF_FFFF_FFFF, 1'b1, 8'hFF, 16'hFFFF, 1'b0};
    vecs[5] = '{44'h000_0000_0000, 1'b0, 8'h00, 16'h0000, 1'b0};

    dec_if.bit_in      = 1'b0;
    dec_if.bit_toggle  = 1'b0;
    dec_if.stream_done = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge sqwv);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].lead) send_half(1'b1, 0);
      send_bits(vecs[i].frame, FB, 0);
      settle();
      exp_cnt++;
      expect_frame($sformatf("vec%0d", i), vecs[i].frame, vecs[i].fac, vecs[i].card,
                   vecs[i].par, exp_cnt);
    end

    // Pair 00 after 10 valid bits; frame_data must hold
    f = 44'hA5A_5A5A_5A5A;
    send_bits(f, 10, 1);
    send_half(1'b0, 0);
    send_half(1'b0, 0);
    settle();
    expect_err("pair00", ERR_PAIR);
    check("pair00_code_out", dec_if.err_code, ERR_PAIR);
    check("pair00_data_held", dec_if.frame_data, vecs[5].frame);
    random_frame("after_pair00", 0);

    // Pair 11 with bit_cnt != 0 is an error, not a slip
    send_bits(f, 5, 0);
    send_half(1'b1, 0);
    send_half(1'b1, 0);
    settle();
    expect_err("pair11_mid", ERR_PAIR);

    // Only one slip per frame: 1,1 slips, then 1,1 again errors
    send_half(1'b1, 0);
    send_half(1'b1, 0);
    send_half(1'b1, 0);
    settle();
    expect_err("second_slip", ERR_PAIR);
    random_frame("after_slip_err", 1);

    // Short frame on stream_done rise
    send_bits(f, 20, 0);
    @(negedge sqwv);
    dec_if.stream_done = 1'b1;
    settle();
    expect_err("short", ERR_SHORT);
    check("short_code_out", dec_if.err_code, ERR_SHORT);
    dec_if.stream_done = 1'b0;
    settle();
    dec_if.stream_done = 1'b1;
    settle();
    check("idle_done_nerr", err_q.size(), 0);
    // Decoding continues while done is held high
    random_frame("done_held", 0);
    dec_if.stream_done = 1'b0;
    settle();

    // Stream end with only a first half pending
    send_half(1'b1, 0);
    @(negedge sqwv);
    dec_if.stream_done = 1'b1;
    settle();
    expect_err("done_half1", ERR_SHORT);
    dec_if.stream_done = 1'b0;
    settle();

    // Stream end coincides with the final half-bit: frame discarded
    send_bits(f, FB - 1, 0);
    send_half(f[0], 0);
    @(negedge sqwv);
    dec_if.bit_in      = ~f[0];
    dec_if.bit_toggle  = ~dec_if.bit_toggle;
    dec_if.stream_done = 1'b1;
    settle();
    expect_err("done_last_evt", ERR_SHORT);
    check("done_last_cnt", dec_if.frame_cnt, exp_cnt);
    dec_if.stream_done = 1'b0;
    settle();

    // Randomized frames with random half-bit spacing
    for (int k = 0; k < 30; k++) random_frame($sformatf("rnd%0d", k), 2);

    // frame_cnt wrap over 256 back-to-back frames from reset
    @(negedge sqwv);
    rst_n = 1'b0;
    dec_if.bit_toggle = 1'b0;
    #1 check("wrap_reset_cnt", dec_if.frame_cnt, 0);
    @(negedge sqwv);
    rst_n = 1'b1;
    obs_q.delete();
    err_q.delete();
    for (int j = 0; j < 256; j++) begin
      f = {12'($urandom), $urandom};
      send_bits(f, FB, 0);
      if (j == 254) begin
        settle();
        check("wrap_cnt_255", dec_if.frame_cnt, 8'd255);
      end
    end
    settle();
    check("wrap_nvalid", obs_q.size(), 256);
    check("wrap_cnt_0", dec_if.frame_cnt, 8'd0);
    check("wrap_last_data", dec_if.frame_data, f);
    check("wrap_nerr", err_q.size(), 0);
    obs_q.delete();

    // Mid-frame reset clears everything immediately
    send_bits(f, 3, 0);
    send_half(1'b0, 0);
    send_half(1'b0, 0);
    settle();
    expect_err("pre_rst_err", ERR_PAIR);
    send_bits(f, 15, 0);
    @(posedge sqwv);
    #2;
    check("pre_rst_data", dec_if.frame_data, f);
    rst_n = 1'b0;
    dec_if.bit_toggle = 1'b0;
    #1 check_all_zero("midrst");
    @(negedge sqwv);
    rst_n = 1'b1;
    exp_cnt = 8'd0;
    random_frame("post_rst", 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
